t_stream_deframer: RTL and testbench

Receive-side counterpart of the D-to-T flip-flop conversion. It accepts a toggle-encoded bit stream (T bits), where each T bit is the XOR of the wanted D bit with the previous D bit. It rebuilds the D stream with an internal toggle register and deframes start/data/stop frames into parallel words. Each word is delivered on a valid/ready output port, with pulsed framing-error and overrun flags.

---
 rtl/t_stream_deframer_if.sv | 28 ++
 rtl/t_stream_deframer.sv | 114 +++++++++++
 tb/tb_t_stream_deframer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/t_stream_deframer_if.sv
// t_stream_deframer_if
//   Bundles the toggle-stream input, the reconstructed line and the
//   valid/ready word output of the deframer.
//   master : producer/consumer side (drives t_in, t_valid, data_ready)
//   slave  : deframer side (drives q, data_out, data_valid, flags)
//   WIDTH  : data bits per frame, must match the deframer's WIDTH
interface t_stream_deframer_if #(
  parameter int WIDTH = 8
);
  logic             t_in;
  logic             t_valid;
  logic             q;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             framing_error;
  logic             overrun;

  modport master (
    output t_in, t_valid, data_ready,
    input  q, data_out, data_valid, framing_error, overrun
  );

  modport slave (
    input  t_in, t_valid, data_ready,
    output q, data_out, data_valid, framing_error, overrun
  );
endinterface

// File: rtl/t_stream_deframer.sv
// t_stream_deframer
//   Rebuilds a D-domain bit stream from toggle-encoded bits (d = q ^ t_in)
//   and deframes start(1) / WIDTH data bits LSB first / stop(0) frames into
//   parallel words delivered on a valid/ready port.
// Ports:
//   clk    : single clock, all state on rising edge
//   reset  : synchronous, active-high, overrides everything else
//   bus    : t_stream_deframer_if.slave
//            t_in/t_valid   toggle bit, consumed on edges with t_valid=1
//            q              reconstructed D line
//            data_out       last delivered word (LSB = first data bit)
//            data_valid     data_out holds an unconsumed word
//            data_ready     consumer accept, ignored while data_valid=0
//            framing_error  1-cycle pulse, stop bit decoded as 1
//            overrun        1-cycle pulse, word dropped (output full)
module t_stream_deframer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  t_stream_deframer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sreg;
  logic             q_r;
  logic [WIDTH-1:0] data_out_r;
  logic             data_valid_r;
  logic             framing_error_r;
  logic             overrun_r;

  logic d;
  logic word_done;
  logic consume;

  // Decoded bit for the current edge; only meaningful when t_valid=1.
  assign d         = q_r ^ bus.t_in;
  assign word_done = bus.t_valid && (state == STOP) && !d;
  assign consume   = data_valid_r && bus.data_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      sreg            <= '0;
      q_r             <= 1'b0;
      data_out_r      <= '0;
      data_valid_r    <= 1'b0;
      framing_error_r <= 1'b0;
      overrun_r       <= 1'b0;
    end else begin
      framing_error_r <= 1'b0;
      overrun_r       <= 1'b0;

      if (bus.t_valid) begin
        q_r <= d;
        unique case (state)
          IDLE: begin
            if (d) begin
              state <= DATA;
              count <= '0;
            end
          end
          DATA: begin
            for (int i = 0; i < WIDTH; i++) begin
              if (count == CW'(i)) sreg[i] <= d;
            end
            if (count == LAST) begin
              state <= STOP;
            end else begin
              count <= count + 1'b1;
            end
          end
          STOP: begin
            // A 1 here is a broken stop bit, never a new start bit.
            if (d) framing_error_r <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      // A completion can land in the same edge as a consume; the new word
      // then replaces the consumed one and data_valid stays high.
      if (word_done) begin
        if (!data_valid_r || bus.data_ready) begin
          data_out_r   <= sreg;
          data_valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (consume) begin
        data_valid_r <= 1'b0;
      end
    end
  end

  assign bus.q             = q_r;
  assign bus.data_out      = data_out_r;
  assign bus.data_valid    = data_valid_r;
  assign bus.framing_error = framing_error_r;
  assign bus.overrun       = overrun_r;

endmodule

// File: tb/tb_t_stream_deframer.sv
module tb_t_stream_deframer;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic tb_q;   // bench's own copy of the reconstructed line, for encoding

  t_stream_deframer_if #(.WIDTH(WIDTH)) bus ();

  t_stream_deframer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one raw toggle bit on a single t_valid edge.
  task automatic send_t(input logic t);
    bus.t_in    = t;
    bus.t_valid = 1'b1;
    step();
    tb_q        = tb_q ^ t;
    bus.t_valid = 1'b0;
  endtask

  // Send one D-domain bit, encoded against the bench's line copy.
  task automatic send_bit(input logic d);
    send_t(d ^ tb_q);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] word, input logic stop_d);
    send_bit(1'b1);
    for (int i = 0; i < WIDTH; i++) send_bit(word[i]);
    send_bit(stop_d);
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.t_in       = 1'b1;
    bus.t_valid    = 1'b1;
    bus.data_ready = 1'b0;
    step();
    step();
    reset       = 1'b0;
    bus.t_valid = 1'b0;
    bus.t_in    = 1'b0;
    tb_q        = 1'b0;
    total++;
    if (bus.q !== 1'b0) begin
      bad++; $display("FAIL reset_q: got %b want 0", bus.q);
    end
    total++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== 8'h00) begin
      bad++; $display("FAIL reset_out: got dv=%b data=%h want dv=0 data=00",
                      bus.data_valid, bus.data_out);
    end
    total++;
    if (bus.framing_error !== 1'b0 || bus.overrun !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got fe=%b ov=%b want 0 0",
                      bus.framing_error, bus.overrun);
    end
  endtask

  // Hand-encoded 0xA5 frame, t_valid every cycle.
  task automatic test_basic();
    logic [9:0] tv;
    tv = 10'b1111011101;  // sent LSB first: 1,0,1,1,1,0,1,1,1,1
    bus.data_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_t(tv[i]);
      if (i == 0) begin
        total++;
        if (bus.q !== 1'b1) begin
          bad++; $display("FAIL basic_q_start: got %b want 1", bus.q);
        end
      end
    end
    total++;
    if (bus.q !== 1'b0) begin
      bad++; $display("FAIL basic_q_end: got %b want 0", bus.q);
    end
    total++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hA5) begin
      bad++; $display("FAIL basic_word: got dv=%b data=%h want dv=1 data=a5",
                      bus.data_valid, bus.data_out);
    end
    step();
    total++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== 8'hA5) begin
      bad++; $display("FAIL basic_consume: got dv=%b data=%h want dv=0 data=a5",
                      bus.data_valid, bus.data_out);
    end
  endtask

  // Same frame with an idle cycle after every bit; q must hold when idle.
  task automatic test_gapped();
    logic [9:0] tv;
    logic       qh;
    int         qbad;
    tv   = 10'b1111011101;
    qbad = 0;
    bus.data_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_t(tv[i]);
      qh = bus.q;
      if (i == 9) begin
        total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hA5) begin
          bad++; $display("FAIL gap_word: got dv=%b data=%h want dv=1 data=a5",
                          bus.data_valid, bus.data_out);
        end
      end
      bus.t_in = 1'b1;  // must be ignored while t_valid=0
      step();
      if (bus.q !== qh) qbad++;
    end
    total++;
    if (qbad != 0 || bus.q !== 1'b0) begin
      bad++; $display("FAIL gap_q_hold: got %0d idle changes q=%b want 0 changes q=0",
                      qbad, bus.q);
    end
    total++;
    if (bus.data_valid !== 1'b0) begin
      bad++; $display("FAIL gap_consume: got dv=%b want 0", bus.data_valid);
    end
  endtask

  task automatic test_framing();
    bus.data_ready = 1'b1;
    send_frame(8'h5A, 1'b1);
    total++;
    if (bus.framing_error !== 1'b1 || bus.data_valid !== 1'b0) begin
      bad++; $display("FAIL frame_err: got fe=%b dv=%b want fe=1 dv=0",
                      bus.framing_error, bus.data_valid);
    end
    send_bit(1'b1);  // start of next frame, right after the bad stop
    total++;
    if (bus.framing_error !== 1'b0) begin
      bad++; $display("FAIL frame_err_pulse: got fe=%b want 0", bus.framing_error);
    end
    for (int i = 0; i < WIDTH; i++) send_bit(logic'(8'h3C >> i));
    send_bit(1'b0);
    total++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h3C) begin
      bad++; $display("FAIL frame_recover: got dv=%b data=%h want dv=1 data=3c",
                      bus.data_valid, bus.data_out);
    end
    step();
  endtask

  task automatic test_overrun();
    bus.data_ready = 1'b0;
    send_frame(8'hA5, 1'b0);
    total++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hA5 || bus.overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_first: got dv=%b data=%h ov=%b want dv=1 data=a5 ov=0",
                      bus.data_valid, bus.data_out, bus.overrun);
    end
    send_frame(8'h3C, 1'b0);
    total++;
    if (bus.overrun !== 1'b1 || bus.data_out !== 8'hA5 || bus.data_valid !== 1'b1) begin
      bad++; $display("FAIL ovr_pulse: got ov=%b data=%h dv=%b want ov=1 data=a5 dv=1",
                      bus.overrun, bus.data_out, bus.data_valid);
    end
    step();
    total++;
    if (bus.overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_one_cycle: got %b want 0", bus.overrun);
    end
    bus.data_ready = 1'b1;
    step();
    total++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== 8'hA5) begin
      bad++; $display("FAIL ovr_drain: got dv=%b data=%h want dv=0 data=a5",
                      bus.data_valid, bus.data_out);
    end
  endtask

  // Completion on the same edge the held word is consumed.
  task automatic test_back_to_back();
    bus.data_ready = 1'b0;
    send_frame(8'h11, 1'b0);
    send_bit(1'b1);
    for (int i = 0; i < WIDTH; i++) send_bit(logic'(8'hEE >> i));
    bus.data_ready = 1'b1;
    send_bit(1'b0);
    total++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hEE || bus.overrun !== 1'b0) begin
      bad++; $display("FAIL b2b_replace: got dv=%b data=%h ov=%b want dv=1 data=ee ov=0",
                      bus.data_valid, bus.data_out, bus.overrun);
    end
    // back-to-back with consumer always ready
    send_frame(8'h81, 1'b0);
    total++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h81) begin
      bad++; $display("FAIL b2b_next: got dv=%b data=%h want dv=1 data=81",
                      bus.data_valid, bus.data_out);
    end
    step();
  endtask

  task automatic test_mid_reset();
    bus.data_ready = 1'b0;
    send_frame(8'h42, 1'b0);  // leave a word held so reset has work to undo
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(logic'(8'h96 >> i));
    reset       = 1'b1;
    bus.t_valid = 1'b1;
    bus.t_in    = 1'b1;
    step();
    reset       = 1'b0;
    bus.t_valid = 1'b0;
    tb_q        = 1'b0;
    total++;
    if (bus.q !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_out !== 8'h00 ||
        bus.framing_error !== 1'b0 || bus.overrun !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got q=%b dv=%b data=%h fe=%b ov=%b want all 0",
                      bus.q, bus.data_valid, bus.data_out, bus.framing_error, bus.overrun);
    end
    step();
    total++;
    if (bus.framing_error !== 1'b0 || bus.overrun !== 1'b0) begin
      bad++; $display("FAIL mid_reset_flags: got fe=%b ov=%b want 0 0",
                      bus.framing_error, bus.overrun);
    end
    bus.data_ready = 1'b1;
    send_frame(8'h96, 1'b0);
    total++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h96) begin
      bad++; $display("FAIL mid_reset_next: got dv=%b data=%h want dv=1 data=96",
                      bus.data_valid, bus.data_out);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    tb_q           = 1'b0;
    reset          = 1'b1;
    bus.t_in       = 1'b0;
    bus.t_valid    = 1'b0;
    bus.data_ready = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
